// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4-to-1 mux.
// It drives a registered one-hot grant, the mux select and a busy flag.
// Optional per-owner burst cap: define ARB_BURST_LIMIT_EN to enable it.
module mux4_rr_arbiter #(
    parameter int BURST_MAX = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Elaboration-time check of the burst cap range
    if (BURST_MAX < 2 || BURST_MAX > 255) begin : g_bad_burst_max
        $error("BURST_MAX out of range 2..255");
    end

    // Scan mask from base upward (mod 4); returns {found, index}
    function automatic logic [2:0] arb_pick(input logic [3:0] mask, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (mask[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t     state_r, state_s;
    logic [1:0] owner_r, owner_s;
    logic [1:0] ptr_r, ptr_s;
    logic [3:0] gnt_r, gnt_s;
    logic [1:0] sel_r, sel_s;
    logic       busy_r, busy_s;
    logic [3:0] masked_s;
    logic [2:0] pick_all_s;
    logic [2:0] pick_masked_s;

`ifdef ARB_BURST_LIMIT_EN
    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);
    logic [7:0] cnt_r, cnt_s;
`endif

    assign masked_s      = req & ~(4'b0001 << owner_r);
    assign pick_all_s    = arb_pick(req, ptr_r);
    assign pick_masked_s = arb_pick(masked_s, ptr_r);

    // Next-state, grant and pointer computation
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        ptr_s   = ptr_r;
        gnt_s   = gnt_r;
        sel_s   = sel_r;
        busy_s  = busy_r;
`ifdef ARB_BURST_LIMIT_EN
        cnt_s   = cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (pick_all_s[2]) begin
                    state_s = OWN;
                    owner_s = pick_all_s[1:0];
                    ptr_s   = pick_all_s[1:0] + 2'd1;
                    gnt_s   = 4'b0001 << pick_all_s[1:0];
                    sel_s   = pick_all_s[1:0];
                    busy_s  = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
                    cnt_s   = 8'd1;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            OWN: begin
                if (!req[owner_r]
`ifdef ARB_BURST_LIMIT_EN
                    || (cnt_r == BURST_LIM && pick_masked_s[2])
`endif
                   ) begin
                    // Release or forced rotation: hand over with no bubble if possible
                    if (pick_masked_s[2]) begin
                        owner_s = pick_masked_s[1:0];
                        ptr_s   = pick_masked_s[1:0] + 2'd1;
                        gnt_s   = 4'b0001 << pick_masked_s[1:0];
                        sel_s   = pick_masked_s[1:0];
                        busy_s  = 1'b1;
`ifdef ARB_BURST_LIMIT_EN
                        cnt_s   = 8'd1;
`endif
                    end else begin
                        state_s = IDLE;
                        gnt_s   = 4'b0000;
                        busy_s  = 1'b0;
                    end
                end else begin
`ifdef ARB_BURST_LIMIT_EN
                    if (cnt_r < BURST_LIM) begin
                        cnt_s = cnt_r + 8'd1;
                    end else begin
                        cnt_s = BURST_LIM;
                    end
`else
                    state_s = OWN;
`endif
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = 4'b0000;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            owner_r <= 2'd0;
            ptr_r   <= 2'd0;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'b00;
            busy_r  <= 1'b0;
`ifdef ARB_BURST_LIMIT_EN
            cnt_r   <= 8'd0;
`endif
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            ptr_r   <= ptr_s;
            gnt_r   <= gnt_s;
            sel_r   <= sel_s;
            busy_r  <= busy_s;
`ifdef ARB_BURST_LIMIT_EN
            cnt_r   <= cnt_s;
`endif
        end
    end

    assign gnt  = gnt_r;
    assign sel  = sel_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, single grant, rotation, tie-break, burst cap.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;

    int n_assert;
    int n_fail;

    mux4_rr_arbiter #(.BURST_MAX(4)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] es, input logic eb);
        n_assert++;
        assert (gnt === eg) else begin
            n_fail++;
            $error("FAIL %s gnt: got %b expected %b", tag, gnt, eg);
        end
        n_assert++;
        assert (sel === es) else begin
            n_fail++;
            $error("FAIL %s sel: got %b expected %b", tag, sel, es);
        end
        n_assert++;
        assert (busy === eb) else begin
            n_fail++;
            $error("FAIL %s busy: got %b expected %b", tag, busy, eb);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        req      = 4'b1111;
        tick();
        tick();
        chk("reset_hold", 4'b0000, 2'b00, 1'b0);

        // Requests already high at release: requester 0 first, then rotation
        reset = 1'b0;
        tick(); chk("rot_0a", 4'b0001, 2'b00, 1'b1);
        tick(); chk("rot_0b", 4'b0001, 2'b00, 1'b1);
        req = 4'b1110;
        tick(); chk("rot_1a", 4'b0010, 2'b01, 1'b1);
        req = 4'b1111;
        tick(); chk("rot_1b", 4'b0010, 2'b01, 1'b1);
        req = 4'b1101;
        tick(); chk("rot_2a", 4'b0100, 2'b10, 1'b1);
        req = 4'b1111;
        tick(); chk("rot_2b", 4'b0100, 2'b10, 1'b1);
        req = 4'b1011;
        tick(); chk("rot_3a", 4'b1000, 2'b11, 1'b1);
        req = 4'b1111;
        tick(); chk("rot_3b", 4'b1000, 2'b11, 1'b1);
        req = 4'b0111;
        tick(); chk("rot_0c", 4'b0001, 2'b00, 1'b1);

        // Asynchronous reset mid-grant, observed before any clock edge
        reset = 1'b1;
        #1;
        chk("reset_async", 4'b0000, 2'b00, 1'b0);
        req = 4'b0000;
        tick();
        reset = 1'b0;

        // Single requester and idle select hold
        tick(); chk("idle", 4'b0000, 2'b00, 1'b0);
        req = 4'b0100;
        tick(); chk("single_gnt", 4'b0100, 2'b10, 1'b1);
        req = 4'b0000;
        tick(); chk("single_rel", 4'b0000, 2'b10, 1'b0);
        tick(); chk("single_idle", 4'b0000, 2'b10, 1'b0);

        // Tie after wrap: owner 3 leaves ptr at 0, so 1 beats 3
        req = 4'b1000;
        tick(); chk("wrap_own3", 4'b1000, 2'b11, 1'b1);
        req = 4'b0000;
        tick(); chk("wrap_idle", 4'b0000, 2'b11, 1'b0);
        req = 4'b1010;
        tick(); chk("wrap_tie", 4'b0010, 2'b01, 1'b1);
        req = 4'b0000;
        tick(); chk("wrap_rel", 4'b0000, 2'b01, 1'b0);

        // ptr is 2: requester 0 wins over 1 for req=0011
        req = 4'b0011;
        tick(); chk("burst_first", 4'b0001, 2'b00, 1'b1);
`ifdef ARB_BURST_LIMIT_EN
        for (int i = 0; i < 3; i++) begin
            tick(); chk("burst_hold", 4'b0001, 2'b00, 1'b1);
        end
        tick(); chk("burst_rotate", 4'b0010, 2'b01, 1'b1);
        req = 4'b0001;
        tick(); chk("burst_back0", 4'b0001, 2'b00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(); chk("burst_alone", 4'b0001, 2'b00, 1'b1);
        end
        req = 4'b0011;
        tick(); chk("burst_sat_rot", 4'b0010, 2'b01, 1'b1);
`else
        for (int i = 0; i < 22; i++) begin
            tick(); chk("nolimit_hold", 4'b0001, 2'b00, 1'b1);
        end
        req = 4'b0010;
        tick(); chk("nolimit_hand", 4'b0010, 2'b01, 1'b1);
`endif
        req = 4'b0000;
        tick(); chk("final_idle", 4'b0000, 2'b01, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter sharing one 4-to-1 mux datapath among four requesters. It accepts per-requester request lines and issues a registered one-hot grant. It also drives the 2-bit mux select so the granted source's bit reaches the shared output. Optionally, it caps how long one requester may hold the mux while others wait.

## Interface
- `BURST_MAX`, default 8: maximum consecutive grant cycles for one owner while another requester is pending. Legal range is 2..255; it is only used when `ARB_BURST_LIMIT_EN` is defined.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req` input 4: request lines; bit i is requester i. Level-held for as long as access is wanted.
- `gnt` output 4: registered one-hot grant, or all-zero when idle.
- `sel` output 2: registered index of the current or last owner; connects directly to the mux `S` input.
- `busy` output 1: registered; high whenever `gnt` is nonzero.

## Operation
- There are two states: IDLE and OWN. Internal registers are `owner[1:0]`, `ptr[1:0]` (the highest-priority index for the next arbitration), and, under the macro, `cnt[7:0]`.
- **Arbitration function:** scan requesters in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) over a candidate mask, and pick the first set bit.
- **IDLE:**
  - If `req` is nonzero, arbitrate over `req`, set `owner`, load `gnt`, `sel` and `busy`, and go to OWN.
  - Otherwise stay in IDLE.
- **OWN with `req[owner]` still high:** keep the grant.
- **OWN with `req[owner]` low (release):**
  - Arbitrate over `req` with the owner bit masked.
  - If there is a winner, hand over directly to it with no idle cycle.
  - If there is none, return to IDLE with `gnt`=0 and `busy`=0.
- **On every new grant:** set `ptr` to winner+1 (mod 4).
- **Idle select:** `sel` holds the last owner's index while in IDLE, so the mux output stays stable.
- **Reset:** an asynchronous clear, taking effect immediately, even mid-grant. It forces IDLE, `gnt`=4'b0000, `sel`=2'b00, `busy`=0, `owner`=0, `ptr`=0 and `cnt`=0.
- **Requests at reset release:** if requests are already high when reset deasserts, requester 0 has the highest priority at the first edge.
- **Invariant:** `gnt` is always one-hot or zero, and `gnt[sel]` equals `busy`.

## Timing
- **Grant latency:** `req` seen high at edge N gives `gnt` and `sel` valid after edge N, in the same cycle as `busy`. A request rising between edges is granted at the next edge.
- **Release latency:**
  - `req[owner]` seen low at edge N removes the grant after edge N.
  - The next owner's grant appears after that same edge N (zero-bubble handover).
- **Simultaneous requests:** ties are resolved by `ptr` order only.
- **Fairness:** a continuously requesting source is granted within 3 intervening grants.
- **Burst counter (`cnt`, under the macro only):**
  - Loaded to 1 on each new grant.
  - Increments each OWN cycle the owner keeps its request.
  - Saturates at `BURST_MAX`.

## Configuration
- **`ARB_BURST_LIMIT_EN` defined:**
  - In OWN, if `cnt` equals `BURST_MAX` and another request is pending (`req` with the owner masked is nonzero), the grant is forcibly rotated at that edge to the arbitration winner over the masked `req`.
  - The pre-empted owner then competes normally later.
  - If no other request is pending, the owner keeps the grant and `cnt` stays saturated.
- **`ARB_BURST_LIMIT_EN` undefined:**
  - `cnt` and the pre-emption logic are absent.
  - An owner holds the grant until it drops its request.
  - `BURST_MAX` is ignored.

## Test plan
- **Reset:** hold `reset`=1 with `req`=4'b1111, then assert `reset` asynchronously mid-grant. Outputs must read `gnt`=0000, `sel`=00 and `busy`=0 immediately, without waiting for a clock edge.
- **Single requester:** `req`=0100 from idle. After one edge, `gnt`=0100, `sel`=10 and `busy`=1. Drop `req`; after the next edge, `gnt`=0000, `busy`=0 and `sel` stays 10.
- **Rotation:** from reset, apply `req`=1111 and have each owner drop its bit for one cycle after holding 2 cycles. Grants must follow 0001, then 0010, 0100, 1000, 0001, with no idle cycle between owners.
- **Tie after wrap:** last owner is 3 and `ptr`=0; apply `req`=1010. Winner is requester 1: `gnt`=0010, `sel`=01.
- **Burst limit (macro on, `BURST_MAX`=4):**
  - Owner 0 holds while `req`=0011.
  - After 4 grant cycles, `gnt` moves to 0010.
  - With `req`=0001 only, owner 0 keeps the grant indefinitely.
- **Macro off:** same stimulus as the burst-limit test. Owner 0 keeps `gnt`=0001 for 20+ cycles until `req[0]` drops, then `gnt`=0010 after that edge.
